// File: rtl/gdo_unit.sv
// gdo_unit: sequential signed fixed-point operator with saturation.
// One shared multiplier and one radix-2 restoring divider serve every op.
module gdo_unit #(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    op,
  input  logic [INT_BITS+FRAC_BITS-1:0] a,
  input  logic [INT_BITS+FRAC_BITS-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] result,
  output logic                          sat,
  output logic                          dz
);

  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int Q  = W + FRAC_BITS;
  localparam int XW = 2 * W + 1;
  localparam int CW = $clog2(Q);

  localparam logic [W-1:0] ONE  = W'(1) << FRAC_BITS;
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [XW-1:0] VMAX =
    {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] VMIN =
    {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, POLY, DIV, POST, HOLD} state_t;

  function automatic logic signed [XW-1:0] sx(
    input logic [W-1:0] v);
    return {{(W+1){v[W-1]}}, v};
  endfunction

  function automatic logic clip(input logic signed [XW-1:0] v);
    return (v > VMAX) || (v < VMIN);
  endfunction

  function automatic logic [W-1:0] satv(
    input logic signed [XW-1:0] v);
    if (v > VMAX) return MAXV;
    if (v < VMIN) return MINV;
    return v[W-1:0];
  endfunction

  // |v| with the most negative value pinned to max
  function automatic logic [W-1:0] absx(input logic [W-1:0] v);
    if (!v[W-1]) return v;
    if (v == MINV) return MAXV;
    return -v;
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  state_t         state, nstate;
  logic [2:0]     opr, pcnt;
  logic [W-1:0]   xr, ax, term, dsum, rem, dvs;
  logic [Q-1:0]   dvd, quo;
  logic [CW-1:0]  dcnt;
  logic           aneg, bneg, bzero;

  logic accept;
  assign out_valid = (state == HOLD);
  assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
  assign accept    = in_valid && in_ready;

  logic signed [W-1:0]    ma, mb;
  logic signed [2*W-1:0]  mp;
  logic signed [XW-1:0]   mq, v1;

  always_comb begin
    ma = signed'(a);
    mb = signed'(b);
    if (state == POLY) begin
      ma = signed'(term);
      mb = signed'(ax);
    end
  end

  assign mp = ma * mb;
  assign mq = signed'({mp[2*W-1], mp}) >>> FRAC_BITS;

  always_comb begin
    unique case (op)
      3'd0:    v1 = sx(a) + sx(b);
      3'd1:    v1 = sx(a) - sx(b);
      3'd2:    v1 = mq;
      3'd6:    v1 = a[W-1] ? '0 : sx(ONE);
      3'd7:    v1 = sx(a);
      default: v1 = '0;
    endcase
  end

  logic [W-1:0] x2, p, tk, tnext, dnext;
  logic [1:0]   sh;

  always_comb begin
    x2 = satv(sx(xr) <<< 1);
    p  = satv(mq);
    unique case (pcnt)
      3'd2:    sh = 2'd1;
      3'd3:    sh = 2'd2;
      3'd4:    sh = 2'd1;
      default: sh = 2'd3;
    endcase
    tk = p >> sh;
    if (pcnt == 3'd1) begin
      tnext = ax;
      dnext = satv(sx(ONE) + sx(ONE) + sx(ax));
    end else begin
      tnext = tk;
      dnext = satv(sx(dsum) + sx(tk));
    end
  end

  logic [W:0] rs, rdiff;
  logic       ge;
  assign rs    = {rem, dvd[Q-1]};
  assign rdiff = rs - {1'b0, dvs};
  assign ge    = !rdiff[W];

  logic signed [XW-1:0] qs, vd, vt;
  logic [W-1:0]         sg, pres;
  logic                 psat, pdz, xpos;

  always_comb begin
    qs   = signed'({{(XW-Q){1'b0}}, quo});
    vd   = (aneg ^ bneg) ? -qs : qs;
    xpos = !xr[W-1] && (xr != '0);
    sg   = xpos ? ONE - quo[W-1:0] : quo[W-1:0];
    vt   = (sx(sg) <<< 1) - sx(ONE);
    pres = satv(vt);
    psat = clip(vt);
    pdz  = 1'b0;
    unique case (1'b1)
      (opr == 3'd3): begin
        pres = satv(vd);
        psat = clip(vd);
        if (bzero) begin
          pres = aneg ? MINV : MAXV;
          psat = 1'b0;
          pdz  = 1'b1;
        end
      end
      (opr == 3'd4): begin
        pres = sg;
        psat = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE, HOLD: begin
        if (accept) begin
          if (op == 3'd3) nstate = DIV;
          else if (op == 3'd4 || op == 3'd5) nstate = POLY;
          else nstate = HOLD;
        end else if (state == HOLD && out_ready) begin
          nstate = IDLE;
        end
      end
      POLY: if (pcnt == 3'd5) nstate = DIV;
      DIV:  if (dcnt == CW'(Q-1)) nstate = POST;
      POST: nstate = HOLD;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr <= '0; pcnt <= '0; xr <= '0; ax <= '0;
      term <= '0; dsum <= '0; rem <= '0; dvs <= '0;
      dvd <= '0; quo <= '0; dcnt <= '0;
      aneg <= 1'b0; bneg <= 1'b0; bzero <= 1'b0;
      result <= '0; sat <= 1'b0; dz <= 1'b0;
    end else if (accept) begin
      opr   <= op;
      xr    <= a;
      ax    <= absx(a);
      aneg  <= a[W-1];
      bneg  <= b[W-1];
      bzero <= (b == '0);
      pcnt  <= (op == 3'd5) ? 3'd0 : 3'd1;
      dvd   <= {mag(a), {FRAC_BITS{1'b0}}};
      dvs   <= mag(b);
      rem   <= '0;
      quo   <= '0;
      dcnt  <= '0;
      sat   <= 1'b0;
      dz    <= 1'b0;
      if (op != 3'd3 && op != 3'd4 && op != 3'd5) begin
        result <= satv(v1);
        sat    <= clip(v1);
      end
    end else begin
      unique case (state)
        POLY: begin
          if (pcnt == 3'd0) begin
            xr <= x2;
            ax <= absx(x2);
          end else begin
            term <= tnext;
            dsum <= dnext;
            dvd  <= {ONE, {FRAC_BITS{1'b0}}};
            dvs  <= dnext;
          end
          pcnt <= pcnt + 3'd1;
        end
        DIV: begin
          rem  <= ge ? rdiff[W-1:0] : rs[W-1:0];
          quo  <= {quo[Q-2:0], ge};
          dvd  <= dvd << 1;
          dcnt <= dcnt + CW'(1);
        end
        POST: begin
          result <= pres;
          sat    <= psat;
          dz     <= pdz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gdo_unit.sv
// tb_gdo_unit: directed table, random ops against an arithmetic model,
// backpressure and mid-operation reset sequences.
module tb_gdo_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [15:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        sat, dz;

  int checks = 0;
  int errors = 0;

  gdo_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat(sat), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        sat, dz;
    int          lat;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v, output logic s);
    s = 1'b1;
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    s = 1'b0;
    return v;
  endfunction

  // Latency is counted in edges after the accept edge; single-cycle
  // ops are already valid in the cycle right after the accept.
  function automatic void model(input logic [2:0] o,
    input logic [15:0] x, y, output logic [15:0] r,
    output logic s, output logic z, output int lat);
    longint sa, sb, v, q, xx, ax, t, d, pp, sg;
    logic   ds;
    int     shf [4];
    shf = '{1, 2, 1, 3};
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    z = 1'b0;
    lat = 0;
    v = 0;
    case (o)
      3'd0: v = sa + sb;
      3'd1: v = sa - sb;
      3'd2: v = (sa * sb) >>> 8;
      3'd3: begin
        lat = 25;
        if (sb == 0) begin
          z = 1'b1;
          v = (sa >= 0) ? 32767 : -32768;
        end else begin
          q = ((sa < 0 ? -sa : sa) * 256) / (sb < 0 ? -sb : sb);
          v = ((sa < 0) != (sb < 0)) ? -q : q;
        end
      end
      3'd4, 3'd5: begin
        xx = sa;
        lat = 30;
        if (o == 3'd5) begin
          xx = clamp(2 * sa, ds);
          lat = 31;
        end
        ax = (xx < 0) ? -xx : xx;
        if (ax > 32767) ax = 32767;
        t = ax;
        d = clamp(512 + t, ds);
        for (int k = 0; k < 4; k++) begin
          pp = clamp((t * ax) >>> 8, ds);
          t = pp >>> shf[k];
          d = clamp(d + t, ds);
        end
        q = 65536 / d;
        sg = (xx > 0) ? 256 - q : q;
        v = (o == 3'd5) ? 2 * sg - 256 : sg;
      end
      3'd6: v = (sa >= 0) ? 256 : 0;
      default: v = sa;
    endcase
    v = clamp(v, s);
    r = v[15:0];
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [15:0] x, y,
    output logic [15:0] r, output logic s, output logic z,
    output int lat);
    int n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept", longint'(n < 100), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    r = result; s = sat; z = dz;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'($urandom_range(0, 1023));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] r, er;
    logic        s, z, es, ez;
    int          lat, el, seen;

    tbl[0]  = '{3'd0, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1, 1'b0, 0};
    tbl[1]  = '{3'd1, 16'h8000, 16'h0100, 16'h8000, 1'b1, 1'b0, 0};
    tbl[2]  = '{3'd2, 16'h0180, 16'hFE00, 16'hFD00, 1'b0, 1'b0, 0};
    tbl[3]  = '{3'd2, 16'h4000, 16'h4000, 16'h7FFF, 1'b1, 1'b0, 0};
    tbl[4]  = '{3'd3, 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25};
    tbl[5]  = '{3'd3, 16'hFF00, 16'h0200, 16'hFF80, 1'b0, 1'b0, 25};
    tbl[6]  = '{3'd3, 16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 25};
    tbl[7]  = '{3'd4, 16'h0000, 16'h1234, 16'h0080, 1'b0, 1'b0, 30};
    tbl[8]  = '{3'd4, 16'h7FFF, 16'h0000, 16'h00FE, 1'b0, 1'b0, 30};
    tbl[9]  = '{3'd4, 16'h8000, 16'h0000, 16'h0002, 1'b0, 1'b0, 30};
    tbl[10] = '{3'd5, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 31};
    tbl[11] = '{3'd6, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 0};

    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_sat", sat, 0);
    chk("rst_dz", dz, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_ready", in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, s, z, lat);
      chk($sformatf("v%0d_res", i), r, tbl[i].res);
      chk($sformatf("v%0d_sat", i), s, tbl[i].sat);
      chk($sformatf("v%0d_dz", i), z, tbl[i].dz);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
    end

    for (int i = 0; i < 120; i++) begin
      logic [2:0]  ro;
      logic [15:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      model(ro, ra, rb, er, es, ez, el);
      do_op(ro, ra, rb, r, s, z, lat);
      chk($sformatf("r%0d_op%0d_res", i, ro), r, er);
      chk($sformatf("r%0d_op%0d_sat", i, ro), s, es);
      chk($sformatf("r%0d_op%0d_dz", i, ro), z, ez);
      chk($sformatf("r%0d_op%0d_lat", i, ro), lat, el);
    end

    // backpressure on a divide result, then drain and accept together
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(3'd3, 16'h0100, 16'h0300, r, s, z, lat);
    chk("bp_res", r, 16'h0055);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i), result, 16'h0055);
      chk($sformatf("bp_flags%0d", i), {sat, dz, out_valid}, 3'b001);
      chk($sformatf("bp_ready%0d", i), in_ready, 0);
    end
    op = 3'd0; a = 16'h0100; b = 16'h0200;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("drain_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_ov", out_valid, 1);
    chk("b2b_res", result, 16'h0300);
    @(posedge clk); #1;
    chk("b2b_drained", out_valid, 0);

    // reset in the middle of a sigmoid
    do_op(3'd7, 16'h5A5A, 16'h0000, r, s, z, lat);
    chk("pre_res", r, 16'h5A5A);
    do_op(3'd0, 16'h0000, 16'h0000, r, s, z, lat);
    op = 3'd4; a = 16'h0200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    do_op(3'd4, 16'h0300, 16'h0000, r, s, z, lat);
    // the first sigmoid finished above; now abort a fresh one mid-flight
    op = 3'd4; a = 16'h0100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_ov", out_valid, 0);
    chk("mid_res", result, 0);
    chk("mid_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_no_ov", seen, 0);
    chk("mid_ready2", in_ready, 1);
    do_op(3'd7, 16'h1234, 16'h0000, r, s, z, lat);
    chk("post_rst_res", r, 16'h1234);
    chk("post_rst_lat", lat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
